// File: rtl/fp_byte_serializer_if.sv
// Sample-side handshake bundle for fp_byte_serializer: compressed float fields plus valid/ready.
`timescale 1ns/1ps
interface fp_byte_serializer_if;
    logic       in_valid;
    logic       in_ready;
    logic       sign;
    logic [2:0] exp_in;
    logic [3:0] sig_in;

    modport master (
        output in_valid,
        output sign,
        output exp_in,
        output sig_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  sign,
        input  exp_in,
        input  sig_in,
        output in_ready
    );
endinterface

// File: rtl/fp_byte_serializer.sv
// Packs {sign,exp,sig} samples into bytes, buffers them in a FIFO and shifts them out MSB-first
// on a framed serial line. Define FP_SER_PARITY_EN to append an even-parity bit to each frame.
`timescale 1ns/1ps
module fp_byte_serializer #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fp_byte_serializer_if.slave    s_if,
    output logic                   ser_out,
    output logic                   ser_frame,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef FP_SER_PARITY_EN
        ST_PARITY = 2'd3,
`endif
        ST_GAP    = 2'd2
    } state_e;

`ifdef FP_SER_PARITY_EN
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    state_e        state_q;
    logic [7:0]    shift_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic          ser_out_q;
    logic          ser_frame_q;
    logic          busy_q;
`ifdef FP_SER_PARITY_EN
    logic          parity_q;
`endif

    logic          in_ready_s;
    logic          push_s;
    logic          pop_s;
    logic          div_last_s;
    logic [7:0]    word_s;
    logic [7:0]    head_s;

    assign in_ready_s = (count_q != CW'(DEPTH));
    assign push_s     = s_if.in_valid && in_ready_s;
    assign pop_s      = (state_q == ST_IDLE) && (count_q != CW'(0));
    assign div_last_s = (div_q == DW'(CLKS_PER_BIT - 1));
    assign word_s     = {s_if.sign, s_if.exp_in, s_if.sig_in};
    assign head_s     = mem_q[rd_ptr_q];

    assign s_if.in_ready = in_ready_s;
    assign ser_out       = ser_out_q;
    assign ser_frame     = ser_frame_q;
    assign busy          = busy_q;
    assign count         = count_q;
    assign ovf           = ovf_q;

    // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
        if (s_if.in_valid && !in_ready_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO pointer, occupancy and sticky overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= word_s;
        end
    end

    // Serializer FSM with registered line outputs; divider restarts on every state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'd0;
            div_q       <= DW'(0);
            bit_q       <= 3'd0;
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FP_SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_q     <= ST_SHIFT;
                        shift_q     <= head_s;
                        div_q       <= DW'(0);
                        bit_q       <= 3'd0;
                        ser_out_q   <= head_s[7];
                        ser_frame_q <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef FP_SER_PARITY_EN
                        parity_q    <= even_parity(head_s);
`endif
                    end
                end
                ST_SHIFT: begin
                    if (div_last_s) begin
                        div_q <= DW'(0);
                        if (bit_q == 3'd7) begin
`ifdef FP_SER_PARITY_EN
                            state_q   <= ST_PARITY;
                            ser_out_q <= parity_q;
`else
                            state_q     <= ST_GAP;
                            ser_out_q   <= 1'b0;
                            ser_frame_q <= 1'b0;
`endif
                        end else begin
                            shift_q   <= {shift_q[6:0], 1'b0};
                            bit_q     <= bit_q + 3'd1;
                            ser_out_q <= shift_q[6];
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
`ifdef FP_SER_PARITY_EN
                ST_PARITY: begin
                    if (div_last_s) begin
                        div_q       <= DW'(0);
                        state_q     <= ST_GAP;
                        ser_out_q   <= 1'b0;
                        ser_frame_q <= 1'b0;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
`endif
                ST_GAP: begin
                    if (div_last_s) begin
                        div_q   <= DW'(0);
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    div_q       <= DW'(0);
                    bit_q       <= 3'd0;
                    ser_out_q   <= 1'b0;
                    ser_frame_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule
